// File: rtl/complete_arbiter.sv
// -----------------------------------------------------------------------------
// complete_arbiter
//
// Round-robin arbiter sharing the single ROB complete port between NUM_FU
// functional units.  Every cycle at most one FU result is accepted (one-hot
// fu_ready), and the accepted packet (ROB index, destination tag, branch
// outcome) is presented on the registered complete_* outputs one cycle later.
// A flush squashes arbitration for the cycle it is high.
//
// Parameters
//   NUM_FU  number of requesting functional units (>= 2)
//   ROB_SZ  ROB depth; ROB index width IDX_W = $clog2(ROB_SZ)
//   TAG_W   physical tag width
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   flush           synchronous squash, active-high
//   fu_valid        per-FU finished-result request
//   fu_rob_idx      per-FU ROB index, FU i at [i*IDX_W +: IDX_W]
//   fu_tag          per-FU destination tag, FU i at [i*TAG_W +: TAG_W]
//   fu_take_branch  per-FU resolved branch outcome
//   fu_ready        one-hot grant (combinational from the registered pointer)
//   complete_en     registered complete-packet valid
//   complete_idx    registered ROB index to mark completed
//   complete_tag    registered tag for the CDB broadcast
//   take_branch     registered branch outcome
//   grant_cnt       saturating number of grants since reset (debug)
// -----------------------------------------------------------------------------
module complete_arbiter #(
  parameter  int NUM_FU = 4,
  parameter  int ROB_SZ = 32,
  parameter  int TAG_W  = 6,
  localparam int IDX_W  = $clog2(ROB_SZ),
  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  logic [NUM_FU*IDX_W-1:0] fu_rob_idx,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic [NUM_FU-1:0]       fu_take_branch,
  output logic [NUM_FU-1:0]       fu_ready,
  output logic                    complete_en,
  output logic [IDX_W-1:0]        complete_idx,
  output logic [TAG_W-1:0]        complete_tag,
  output logic                    take_branch,
  output logic [31:0]             grant_cnt
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Pointer to the FU after the winner, wrapping NUM_FU-1 back to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    return (w == PTR_W'(NUM_FU - 1)) ? '0 : w + 1'b1;
  endfunction

  // State registers
  logic [PTR_W-1:0] ptr_q,  ptr_d;
  logic             en_q,   en_d;
  logic [IDX_W-1:0] idx_q,  idx_d;
  logic [TAG_W-1:0] tag_q,  tag_d;
  logic             br_q,   br_d;
  logic [31:0]      cnt_q,  cnt_d;

  // Unpacked views of the flattened per-FU buses
  logic [IDX_W-1:0] idx_arr [NUM_FU];
  logic [TAG_W-1:0] tag_arr [NUM_FU];

  for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
    assign idx_arr[g] = fu_rob_idx[g*IDX_W +: IDX_W];
    assign tag_arr[g] = fu_tag[g*TAG_W +: TAG_W];
  end

  // ---- Arbitration: search starts at ptr_q and wraps around ----
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic             grant_en;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_FU);
      if (!win_vld && fu_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // A grant is a transfer: the winner is valid by construction.  Reset and
  // flush both suppress the grant so nothing is accepted and then lost.
  assign grant_en = win_vld && !reset && !flush;

  always_comb begin
    fu_ready = '0;
    if (grant_en) begin
      fu_ready[win_idx] = 1'b1;
    end
  end

  // Next state: payload registers only reload on a transfer, so they hold
  // their last value while complete_en is low.
  always_comb begin
    ptr_d = ptr_q;
    en_d  = 1'b0;
    idx_d = idx_q;
    tag_d = tag_q;
    br_d  = br_q;
    cnt_d = cnt_q;
    if (grant_en) begin
      ptr_d = next_ptr(win_idx);
      en_d  = 1'b1;
      idx_d = idx_arr[win_idx];
      tag_d = tag_arr[win_idx];
      br_d  = fu_take_branch[win_idx];
      cnt_d = sat_inc(cnt_q);
    end
  end

  // ---- Complete stage: registered packet presented one cycle after grant ----
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      en_q  <= 1'b0;
      idx_q <= '0;
      tag_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      en_q  <= en_d;
      idx_q <= idx_d;
      tag_q <= tag_d;
      br_q  <= br_d;
      cnt_q <= cnt_d;
    end
  end

  assign complete_en  = en_q;
  assign complete_idx = idx_q;
  assign complete_tag = tag_q;
  assign take_branch  = br_q;
  assign grant_cnt    = cnt_q;

endmodule

// File: tb/tb_complete_arbiter.sv
module tb_complete_arbiter;

  localparam int NUM_FU = 4;
  localparam int ROB_SZ = 32;
  localparam int TAG_W  = 6;
  localparam int IDX_W  = 5;

  logic                    clock = 1'b0;
  logic                    reset, flush;
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*IDX_W-1:0] fu_rob_idx;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU-1:0]       fu_take_branch;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    complete_en;
  logic [IDX_W-1:0]        complete_idx;
  logic [TAG_W-1:0]        complete_tag;
  logic                    take_branch;
  logic [31:0]             grant_cnt;

  complete_arbiter #(.NUM_FU(NUM_FU), .ROB_SZ(ROB_SZ), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_rob_idx(fu_rob_idx), .fu_tag(fu_tag),
    .fu_take_branch(fu_take_branch), .fu_ready(fu_ready),
    .complete_en(complete_en), .complete_idx(complete_idx),
    .complete_tag(complete_tag), .take_branch(take_branch),
    .grant_cnt(grant_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             en;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             br;
  } pkt_t;

  pkt_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-FU payload driven by the tests
  logic [IDX_W-1:0] idx_a [NUM_FU];
  logic [TAG_W-1:0] tag_a [NUM_FU];
  logic             br_a  [NUM_FU];

  // Reference model state
  int          m_ptr = 0;
  logic [31:0] m_cnt = 0;
  logic [3:0]  exp_ready;

  // Drive one cycle of stimulus, compute the expected grant and push the
  // packet the complete port must show after the coming edge.
  task automatic drive(input logic [3:0] v, input logic fl, input logic rs);
    int   w;
    pkt_t p;
    fu_valid = v;
    flush    = fl;
    reset    = rs;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_rob_idx[i*IDX_W +: IDX_W] = idx_a[i];
      fu_tag[i*TAG_W +: TAG_W]     = tag_a[i];
      fu_take_branch[i]            = br_a[i];
    end
    #1;
    w = -1;
    for (int k = 0; k < NUM_FU; k++) begin
      int c;
      c = (m_ptr + k) % NUM_FU;
      if (w < 0 && v[c]) w = c;
    end
    p.en = 1'b0; p.idx = '0; p.tag = '0; p.br = 1'b0;
    exp_ready = 4'b0000;
    if (rs) begin
      m_ptr = 0;
      m_cnt = 0;
    end else if (!fl && w >= 0) begin
      exp_ready = 4'b0001 << w;
      p.en  = 1'b1;
      p.idx = idx_a[w];
      p.tag = tag_a[w];
      p.br  = br_a[w];
      m_ptr = (w + 1) % NUM_FU;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    sb.push_back(p);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Scoreboard: each edge consumes the packet expected from the prior cycle.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      pkt_t e;
      e = sb.pop_front();
      n_cmp++;
      if (complete_en !== e.en) begin
        n_bad++;
        $display("FAIL sb_complete_en: got %b want %b @%0t", complete_en, e.en, $time);
      end
      if (e.en) begin
        n_cmp++;
        if (complete_idx !== e.idx || complete_tag !== e.tag || take_branch !== e.br) begin
          n_bad++;
          $display("FAIL sb_packet: got idx=%0d tag=%h br=%b want idx=%0d tag=%h br=%b @%0t",
                   complete_idx, complete_tag, take_branch, e.idx, e.tag, e.br, $time);
        end
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(4'hF, 1'b0, 1'b1);
      n_cmp++;
      if (fu_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_ready: got %b want 0000", fu_ready);
      end
      tick();
      n_cmp++;
      if (complete_en !== 1'b0 || grant_cnt !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_regs: got en=%b cnt=%0d want en=0 cnt=0", complete_en, grant_cnt);
      end
    end
    drive(4'hF, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_first_grant: got %b want 0001", fu_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    // Re-enter from reset so the pointer starts at FU0
    drive(4'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < NUM_FU; i++) begin
      idx_a[i] = IDX_W'(4 * i + 3);
      tag_a[i] = TAG_W'(16 + i);
      br_a[i]  = i[0];
    end
    for (int c = 0; c < 5; c++) begin
      logic [3:0] want;
      want = 4'b0001 << (c % 4);
      drive(4'hF, 1'b0, 1'b0);
      n_cmp++;
      if (fu_ready !== want || fu_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %b want %b", c, fu_ready, want);
      end
      tick();
      n_cmp++;
      if (complete_en !== 1'b1 || complete_idx !== IDX_W'(4 * (c % 4) + 3)) begin
        n_bad++;
        $display("FAIL rr_complete%0d: got en=%b idx=%0d want en=1 idx=%0d",
                 c, complete_en, complete_idx, 4 * (c % 4) + 3);
      end
    end
    n_cmp++;
    if (grant_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL rr_cnt: got %0d want 5", grant_cnt);
    end
  endtask

  task automatic test_skip_wrap();
    drive(4'b0100, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL skip_fu2: got %b want 0100", fu_ready);
    end
    tick();
    drive(4'b1010, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL skip_fu3: got %b want 1000", fu_ready);
    end
    tick();
    drive(4'b0010, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL wrap_fu1: got %b want 0010", fu_ready);
    end
    tick();
  endtask

  task automatic test_single();
    tag_a[1] = 6'h2A;
    br_a[1]  = 1'b1;
    idx_a[1] = 5'd9;
    drive(4'b0010, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_ready: got %b want 0010", fu_ready);
    end
    tick();
    n_cmp++;
    if (complete_en !== 1'b1 || complete_tag !== 6'h2A || take_branch !== 1'b1) begin
      n_bad++;
      $display("FAIL single_pkt: got en=%b tag=%h br=%b want en=1 tag=2a br=1",
               complete_en, complete_tag, take_branch);
    end
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (complete_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drop: got en=%b want 0", complete_en);
    end
  endtask

  task automatic test_flush();
    logic [31:0] cnt_before;
    // Pointer is at FU2 after the single-requester grant to FU1
    cnt_before = grant_cnt;
    drive(4'b0101, 1'b1, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL flush_ready: got %b want 0000", fu_ready);
    end
    tick();
    n_cmp++;
    if (complete_en !== 1'b0 || grant_cnt !== cnt_before) begin
      n_bad++;
      $display("FAIL flush_regs: got en=%b cnt=%0d want en=0 cnt=%0d",
               complete_en, grant_cnt, cnt_before);
    end
    drive(4'b0101, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL flush_resume: got %b want 0100", fu_ready);
    end
    tick();
    drive(4'b0001, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL flush_next: got %b want 0001", fu_ready);
    end
    tick();
    // Flush and reset together: reset wins and clears the pointer
    drive(4'b1111, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (grant_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL flush_reset_cnt: got %0d want 0", grant_cnt);
    end
    drive(4'b1110, 1'b0, 1'b0);
    n_cmp++;
    if (fu_ready !== 4'b0010 || fu_ready !== exp_ready) begin
      n_bad++;
      $display("FAIL flush_reset_ptr: got %b want 0010", fu_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit got;
    // Pointer now at FU2; FU3 holds stable data while all others compete
    idx_a[3] = 5'd27;
    tag_a[3] = 6'h3C;
    br_a[3]  = 1'b1;
    got = 1'b0;
    for (int c = 0; c < NUM_FU && !got; c++) begin
      drive(4'hF, 1'b0, 1'b0);
      n_cmp++;
      if (fu_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: got %b want %b", c, fu_ready, exp_ready);
      end
      if (fu_ready[3]) got = 1'b1;
      tick();
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL b2b_fairness: got no grant to FU3 want grant within %0d cycles", NUM_FU);
    end
    n_cmp++;
    if (complete_idx !== 5'd27 || complete_tag !== 6'h3C) begin
      n_bad++;
      $display("FAIL b2b_data: got idx=%0d tag=%h want idx=27 tag=3c", complete_idx, complete_tag);
    end
  endtask

  task automatic test_saturation();
    force dut.cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    drive(4'b0001, 1'b0, 1'b0);
    tick();
    release dut.cnt_q;
    drive(4'b0001, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (grant_cnt !== 32'hFFFF_FFFF || grant_cnt !== m_cnt) begin
      n_bad++;
      $display("FAIL sat_cnt: got %h want ffffffff", grant_cnt);
    end
    drive(4'b0000, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    fu_valid       = '0;
    fu_rob_idx     = '0;
    fu_tag         = '0;
    fu_take_branch = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      idx_a[i] = IDX_W'(i);
      tag_a[i] = TAG_W'(i);
      br_a[i]  = 1'b0;
    end
    @(negedge clock);
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_single();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish want finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
